// File: rtl/int_vec_arbiter.sv
// Prioritised interrupt vector arbiter with nesting and an APB config port.
// Ranks pending sources, presents one vector via irq/ack, tracks in-service.
module int_vec_arbiter #(
    parameter int          N_SRC = 8,
    parameter logic [19:0] BASE  = 20'ha0010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             apb_psel,
    input  logic [19:0]      apb_paddr,
    input  logic             apb_pwrite,
    input  logic             apb_penable,
    input  logic [7:0]       apb_pwdata,
    output logic [7:0]       apb_prdata,
    output logic             apb_ack,
    input  logic [N_SRC-1:0] int_pend,
    output logic             cpu_irq,
    output logic [2:0]       cpu_vec,
    input  logic             cpu_ack,
    input  logic             cpu_eoi
);

    typedef enum logic [1:0] {IDLE, ARB, REQ} state_t;

    state_t             state_q, state_d;
    logic [7:0]         prio_lo_q, prio_lo_d;
    logic [7:0]         prio_hi_q, prio_hi_d;
    logic               en_q, en_d;
    logic [N_SRC-1:0]   pend_q, pend_d;
    logic [N_SRC-1:0]   isr_q, isr_d;
    logic [2:0]         win_q, win_d;
    logic [2:0]         vec_q, vec_d;
    logic               irq_q, irq_d;

    logic                  we;
    logic [19:0]           off;
    logic [N_SRC-1:0][1:0] prio;
    logic                  isr_any;
    logic [1:0]            cur_prio;
    logic [N_SRC-1:0]      elig;
    logic                  any_elig;
    logic [2:0]            win_idx;
    logic [1:0]            win_prio;
    logic [2:0]            eoi_idx;
    logic [1:0]            eoi_prio;
    logic [N_SRC-1:0]      eoi_mask;
    logic [N_SRC-1:0]      ack_mask;

    assign we      = apb_psel & apb_penable & apb_pwrite;
    assign off     = apb_paddr - BASE;
    assign prio    = {prio_hi_q, prio_lo_q};
    assign apb_ack = 1'b1;
    assign cpu_irq = irq_q;
    assign cpu_vec = vec_q;

    // Ranking: current in-service level, eligibility, winner and eoi target
    always_comb begin
        isr_any  = |isr_q;
        cur_prio = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (isr_q[i] && prio[i] > cur_prio) cur_prio = prio[i];
        end
        elig = '0;
        for (int i = 0; i < N_SRC; i++) begin
            elig[i] = en_q & pend_q[i] & ~isr_q[i]
                    & (~isr_any | (prio[i] > cur_prio));
        end
        any_elig = |elig;
        // Descending scan with >= lets the lowest index win ties
        win_idx  = '0;
        win_prio = '0;
        eoi_idx  = '0;
        eoi_prio = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (elig[i] && prio[i] >= win_prio) begin
                win_prio = prio[i];
                win_idx  = 3'(i);
            end
            if (isr_q[i] && prio[i] >= eoi_prio) begin
                eoi_prio = prio[i];
                eoi_idx  = 3'(i);
            end
        end
        eoi_mask = (cpu_eoi && isr_any) ? (N_SRC'(1) << eoi_idx) : '0;
    end

    // Register file writes and pending-level sampling
    always_comb begin
        prio_lo_d = prio_lo_q;
        prio_hi_d = prio_hi_q;
        en_d      = en_q;
        pend_d    = int_pend;
        if (we) begin
            case (off)
                20'd0:   prio_lo_d = apb_pwdata;
                20'd1:   prio_hi_d = apb_pwdata;
                20'd2:   en_d      = apb_pwdata[0];
                default: ;
            endcase
        end
    end

    // Handshake FSM; eoi applies to the pre-ack isr, then the ack bit is set
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        vec_d    = vec_q;
        irq_d    = irq_q;
        ack_mask = '0;
        unique case (state_q)
            IDLE: begin
                if (any_elig) begin
                    win_d   = win_idx;
                    state_d = ARB;
                end
            end
            ARB: begin
                state_d = REQ;
                irq_d   = 1'b1;
                vec_d   = win_q;
            end
            REQ: begin
                if (cpu_ack) begin
                    ack_mask = N_SRC'(1) << win_q;
                    irq_d    = 1'b0;
                    state_d  = IDLE;
                end else if (!pend_q[win_q] || !en_q) begin
                    irq_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                irq_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
        isr_d = (isr_q & ~eoi_mask) | ack_mask;
    end

    // APB read mux, no side effects
    always_comb begin
        apb_prdata = '0;
        case (off)
            20'd0:   apb_prdata = prio_lo_q;
            20'd1:   apb_prdata = prio_hi_q;
            20'd2:   apb_prdata = {7'b0, en_q};
            20'd3:   apb_prdata = {irq_q, 4'b0, vec_q};
            20'd4:   apb_prdata = isr_q;
            default: apb_prdata = '0;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            prio_lo_q <= '0;
            prio_hi_q <= '0;
            en_q      <= 1'b0;
            pend_q    <= '0;
            isr_q     <= '0;
            win_q     <= '0;
            vec_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_lo_q <= prio_lo_d;
            prio_hi_q <= prio_hi_d;
            en_q      <= en_d;
            pend_q    <= pend_d;
            isr_q     <= isr_d;
            win_q     <= win_d;
            vec_q     <= vec_d;
            irq_q     <= irq_d;
        end
    end

endmodule
